// File: rtl/vga_term_writer_pkg.sv
// rtl/vga_term_writer_pkg.sv - shared states, control codes and screen defaults
package vga_term_writer_pkg;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 30;

    localparam logic [7:0] CHAR_BS = 8'h08;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_FF = 8'h0C;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_SP = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_GUARD,
        ST_WAIT,
        ST_CLR_WRITE,
        ST_CLR_GUARD,
        ST_CLR_WAIT
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_cursor_ctr.sv
// rtl/vga_cursor_ctr.sv - row/column cursor with wrap and linear cell address
module vga_cursor_ctr #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic              newline_i,
    input  logic              cr_i,
    input  logic              home_i,
    output logic [4:0]        row_o,
    output logic [6:0]        col_o,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic [4:0] row_q, row_d, next_row;
    logic [6:0] col_q, col_d;

    assign next_row = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;

    // Only one request is expected per cycle; home wins so a clear always lands at (0,0).
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (home_i) begin
            row_d = 5'd0;
            col_d = 7'd0;
        end else if (inc_i) begin
            if (col_q == LAST_COL) begin
                col_d = 7'd0;
                row_d = next_row;
            end else begin
                col_d = col_q + 7'd1;
            end
        end else if (dec_i) begin
            if (col_q != 7'd0) col_d = col_q - 7'd1;
        end else if (newline_i) begin
            col_d = 7'd0;
            row_d = next_row;
        end else if (cr_i) begin
            col_d = 7'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= 5'd0;
            col_q <= 7'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o  = row_q;
    assign col_o  = col_q;
    assign addr_o = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

endmodule

// File: rtl/vga_term_writer.sv
// rtl/vga_term_writer.sv - byte stream to VGA text-buffer write sequencer
module vga_term_writer #(
    parameter int COLS   = vga_term_writer_pkg::DEFAULT_COLS,
    parameter int ROWS   = vga_term_writer_pkg::DEFAULT_ROWS,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    input  logic              in_attr,
    output logic              in_ready,
    output logic [ADDR_W-1:0] term_address,
    output logic [8:0]        term_data,
    output logic              term_cs,
    input  logic              term_busy,
    output logic [4:0]        cursor_row,
    output logic [6:0]        cursor_col,
    output logic              clearing
);

    import vga_term_writer_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

    state_t            state_q;
    logic              in_ready_q;
    logic              term_cs_q;
    logic              clearing_q;
    logic              print_q;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        data_q;

    logic              accept;
    logic              do_inc, do_dec, do_nl, do_cr, do_home;
    logic [ADDR_W-1:0] cur_addr;

    assign accept  = (state_q == ST_IDLE) && in_valid && in_ready_q;
    assign do_cr   = accept && (in_char == CHAR_CR);
    assign do_nl   = accept && (in_char == CHAR_LF);
    assign do_dec  = accept && (in_char == CHAR_BS) && (cursor_col != 7'd0);
    assign do_inc  = (state_q == ST_WRITE) && print_q;
    assign do_home = (state_q == ST_CLR_WAIT) && !term_busy && (addr_q == LAST_CELL);

    vga_cursor_ctr #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_cursor (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (do_inc),
        .dec_i     (do_dec),
        .newline_i (do_nl),
        .cr_i      (do_cr),
        .home_i    (do_home),
        .row_o     (cursor_row),
        .col_o     (cursor_col),
        .addr_o    (cur_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            term_cs_q  <= 1'b0;
            clearing_q <= 1'b0;
            print_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= 9'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= !term_busy;
                    if (accept) begin
                        if (is_printable(in_char)) begin
                            addr_q     <= cur_addr;
                            data_q     <= {in_attr, in_char};
                            print_q    <= 1'b1;
                            term_cs_q  <= 1'b1;
                            in_ready_q <= 1'b0;
                            state_q    <= ST_WRITE;
                        end else if (do_dec) begin
                            // Blank the cell the cursor is stepping back onto.
                            addr_q     <= cur_addr - ADDR_W'(1);
                            data_q     <= {1'b0, CHAR_SP};
                            print_q    <= 1'b0;
                            term_cs_q  <= 1'b1;
                            in_ready_q <= 1'b0;
                            state_q    <= ST_WRITE;
                        end else if (in_char == CHAR_FF) begin
                            addr_q     <= '0;
                            data_q     <= {1'b0, CHAR_SP};
                            clearing_q <= 1'b1;
                            term_cs_q  <= 1'b1;
                            in_ready_q <= 1'b0;
                            state_q    <= ST_CLR_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    term_cs_q <= 1'b0;
                    state_q   <= ST_GUARD;
                end
                ST_GUARD: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (!term_busy) begin
                        in_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_CLR_WRITE: begin
                    term_cs_q <= 1'b0;
                    state_q   <= ST_CLR_GUARD;
                end
                ST_CLR_GUARD: state_q <= ST_CLR_WAIT;
                ST_CLR_WAIT: begin
                    if (!term_busy) begin
                        if (addr_q == LAST_CELL) begin
                            clearing_q <= 1'b0;
                            in_ready_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            addr_q    <= addr_q + ADDR_W'(1);
                            term_cs_q <= 1'b1;
                            state_q   <= ST_CLR_WRITE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign term_cs      = term_cs_q;
    assign term_address = addr_q;
    assign term_data    = data_q;
    assign clearing     = clearing_q;

endmodule

// File: tb/tb_vga_term_writer.sv
// tb/tb_vga_term_writer.sv - directed self-checking bench for vga_term_writer
module tb_vga_term_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_char = 8'h00;
    logic        in_attr = 1'b0;
    logic        in_ready;
    logic [11:0] term_address;
    logic [8:0]  term_data;
    logic        term_cs;
    logic        term_busy = 1'b0;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        clearing;

    int pass_cnt = 0;
    int total_cnt = 0;

    int          busy_len = 0;
    int          busy_cnt = 0;
    int          strobes = 0;
    int          busy_viol = 0;
    int          width_err = 0;
    int          clr_err = 0;
    int          clr_idx = 0;
    logic        mon_clear = 1'b0;
    logic        cs_prev = 1'b0;
    logic [11:0] last_addr = '0;
    logic [8:0]  last_data = '0;

    vga_term_writer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_char      (in_char),
        .in_attr      (in_attr),
        .in_ready     (in_ready),
        .term_address (term_address),
        .term_data    (term_data),
        .term_cs      (term_cs),
        .term_busy    (term_busy),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col),
        .clearing     (clearing)
    );

    always #5 clk = ~clk;

    // Terminal model and strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (term_cs) begin
            if (term_busy) busy_viol++;
            if (cs_prev) width_err++;
            strobes++;
            last_addr = term_address;
            last_data = term_data;
            if (mon_clear) begin
                if (term_address != clr_idx[11:0] || term_data != 9'h020 || !clearing) clr_err++;
                clr_idx++;
            end
        end
        cs_prev = term_cs;
        if (busy_cnt > 0) busy_cnt--;
        if (term_cs && busy_len > 0) busy_cnt = busy_len;
        term_busy = (busy_cnt > 0);
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        strobes = 0; busy_viol = 0; width_err = 0; clr_err = 0; clr_idx = 0;
        @(negedge clk);
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        @(negedge clk);
        while ((!in_ready || clearing) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL ready_timeout: in_ready=%0b want 1 after %0d cycles", in_ready, n);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic a);
        wait_ready(2000);
        in_valid = 1'b1;
        in_char  = c;
        in_attr  = a;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_cursor(input string name, input logic [4:0] r, input logic [6:0] c);
        wait_ready(2000);
        total_cnt++;
        if (cursor_row !== r || cursor_col !== c)
            $display("FAIL %s: cursor=(%0d,%0d) want (%0d,%0d)", name, cursor_row, cursor_col, r, c);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({in_ready, term_cs, clearing} !== 3'b000 || term_address !== 12'd0 || term_data !== 9'd0)
            $display("FAIL reset_outputs: ready=%b cs=%b clr=%b addr=%h data=%h want all 0",
                     in_ready, term_cs, clearing, term_address, term_data);
        else pass_cnt++;
        total_cnt++;
        if (cursor_row !== 5'd0 || cursor_col !== 7'd0)
            $display("FAIL reset_cursor: (%0d,%0d) want (0,0)", cursor_row, cursor_col);
        else pass_cnt++;
    endtask

    task automatic test_print();
        do_reset();
        send(8'h41, 1'b1);
        check_cursor("print_cursor", 5'd0, 7'd1);
        total_cnt++;
        if (strobes !== 1 || last_addr !== 12'd0 || last_data !== 9'h141 || width_err !== 0)
            $display("FAIL print_strobe: n=%0d addr=%0d data=%h werr=%0d want 1,0,141,0",
                     strobes, last_addr, last_data, width_err);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 79; i++) send(8'h78, 1'b0);
        send(8'h5A, 1'b0);
        check_cursor("wrap_row_cursor", 5'd1, 7'd0);
        total_cnt++;
        if (last_addr !== 12'd79 || last_data !== 9'h05A || strobes !== 80)
            $display("FAIL wrap_row_write: addr=%0d data=%h n=%0d want 79,05a,80", last_addr, last_data, strobes);
        else pass_cnt++;
        for (int i = 0; i < 28; i++) send(8'h0A, 1'b0);
        for (int i = 0; i < 79; i++) send(8'h78, 1'b0);
        check_cursor("wrap_pre_cursor", 5'd29, 7'd79);
        send(8'h5A, 1'b0);
        check_cursor("wrap_screen_cursor", 5'd0, 7'd0);
        total_cnt++;
        if (last_addr !== 12'd2399 || last_data !== 9'h05A)
            $display("FAIL wrap_screen_write: addr=%0d data=%h want 2399,05a", last_addr, last_data);
        else pass_cnt++;
    endtask

    task automatic test_backspace();
        do_reset();
        send(8'h41, 1'b0);
        send(8'h42, 1'b1);
        send(8'h08, 1'b1);
        check_cursor("bs_cursor", 5'd0, 7'd1);
        total_cnt++;
        if (strobes !== 3 || last_addr !== 12'd1 || last_data !== 9'h020)
            $display("FAIL bs_write: n=%0d addr=%0d data=%h want 3,1,020", strobes, last_addr, last_data);
        else pass_cnt++;
        send(8'h0D, 1'b0);
        send(8'h08, 1'b0);
        check_cursor("bs_col0_cursor", 5'd0, 7'd0);
        total_cnt++;
        if (strobes !== 3)
            $display("FAIL bs_col0_nostrobe: n=%0d want 3", strobes);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        int ready_bad = 0;
        int clr_low = 0;
        int n = 0;
        do_reset();
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        wait_ready(2000);
        strobes = 0;
        clr_idx = 0;
        mon_clear = 1'b1;
        send(8'h0C, 1'b0);
        @(negedge clk);
        while (n < 20000 && !(clearing == 1'b0 && strobes >= 2400)) begin
            if (in_ready) ready_bad++;
            if (!clearing) clr_low++;
            @(negedge clk);
            n++;
        end
        mon_clear = 1'b0;
        total_cnt++;
        if (strobes !== 2400 || clr_idx !== 2400)
            $display("FAIL clear_count: strobes=%0d want 2400", strobes);
        else pass_cnt++;
        total_cnt++;
        if (clr_err !== 0 || width_err !== 0)
            $display("FAIL clear_sequence: bad_cells=%0d width_err=%0d want 0,0", clr_err, width_err);
        else pass_cnt++;
        total_cnt++;
        if (ready_bad !== 0 || clr_low !== 0)
            $display("FAIL clear_flags: ready_high=%0d clearing_low=%0d want 0,0", ready_bad, clr_low);
        else pass_cnt++;
        check_cursor("clear_cursor", 5'd0, 7'd0);
    endtask

    task automatic test_busy();
        busy_len = 10;
        do_reset();
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        check_cursor("busy_cursor", 5'd0, 7'd2);
        total_cnt++;
        if (busy_viol !== 0 || strobes !== 2 || last_addr !== 12'd1 || last_data !== 9'h042)
            $display("FAIL busy_hold: viol=%0d n=%0d addr=%0d data=%h want 0,2,1,042",
                     busy_viol, strobes, last_addr, last_data);
        else pass_cnt++;
        send(8'h0D, 1'b0);
        check_cursor("cr_cursor", 5'd0, 7'd0);
        send(8'h0A, 1'b0);
        check_cursor("lf_cursor", 5'd1, 7'd0);
        send(8'h07, 1'b0);
        send(8'h90, 1'b1);
        check_cursor("drop_cursor", 5'd1, 7'd0);
        total_cnt++;
        if (strobes !== 2)
            $display("FAIL ctrl_nostrobe: n=%0d want 2", strobes);
        else pass_cnt++;
        busy_len = 0;
    endtask

    task automatic test_reset_mid_clear();
        int n = 0;
        do_reset();
        send(8'h0C, 1'b0);
        while (!(term_cs && term_address == 12'd500) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (term_address !== 12'd500)
            $display("FAIL midclr_reach: addr=%0d want 500", term_address);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if (term_cs !== 1'b0 || clearing !== 1'b0)
            $display("FAIL midclr_abort: cs=%b clearing=%b want 0,0", term_cs, clearing);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        strobes = 0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || clearing !== 1'b0 || cursor_row !== 5'd0 || cursor_col !== 7'd0)
            $display("FAIL midclr_idle: ready=%b clr=%b cursor=(%0d,%0d) want 1,0,(0,0)",
                     in_ready, clearing, cursor_row, cursor_col);
        else pass_cnt++;
        send(8'h43, 1'b0);
        check_cursor("midclr_after_cursor", 5'd0, 7'd1);
        total_cnt++;
        if (strobes !== 1 || last_addr !== 12'd0 || last_data !== 9'h043)
            $display("FAIL midclr_after_write: n=%0d addr=%0d data=%h want 1,0,043", strobes, last_addr, last_data);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_print();
        test_wrap();
        test_backspace();
        test_clear();
        test_busy();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
